magma_sched: RTL and testbench

- Arbiter and sequencer that shares one Magma block-cipher core (64-bit block, 256-bit key, roughly 130-cycle iterative datapath) among N_REQ requesters.
- Accepts jobs over per-requester valid/ready channels and grants them round-robin.
- Drives the core's start/data/key/mode inputs and holds them stable for the whole operation.
- Returns each result on a single response channel tagged with the requester ID. A watchdog flags a core that never completes.

---
 rtl/magma_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/magma_sched.sv | 147 ++++++++++++++
 tb/tb_magma_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/magma_pkg.sv
// Shared constants and types for the Magma core scheduler.
// Holds the FSM encoding, datapath widths and the GOST reference vectors.
package magma_pkg;

   localparam int BLK_W       = 64;
   localparam int KEY_W       = 256;
   localparam int TIMEOUT_DEF = 255;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = S_IDLE,
      ISSUE = S_ISSUE,
      WAIT  = S_WAIT,
      RESP  = S_RESP
   } state_e;

   localparam logic [KEY_W-1:0] TV_KEY =
      256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [BLK_W-1:0] TV_PT = 64'hfedcba9876543210;
   localparam logic [BLK_W-1:0] TV_CT = 64'h4ee901e5c2d8ca3d;

   // Successor of index i in a ring of n slots.
   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search starting at a pointer.
// Returns a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int j;

   // First requesting slot at or above the pointer, wrapping around.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_i) + i) % N;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/magma_sched.sv
// Shares one iterative Magma core among N_REQ requesters.
// Round-robin grant, one job in flight, watchdog on core completion.
module magma_sched
   import magma_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int ID_W    = 1,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   reset_,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [BLK_W*N_REQ-1:0] req_data,
   input  logic [KEY_W*N_REQ-1:0] req_key,
   input  logic [N_REQ-1:0]       req_encr,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [BLK_W-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_err,
   output logic                   core_start,
   output logic [BLK_W-1:0]       core_data_in,
   output logic [KEY_W-1:0]       core_key,
   output logic                   core_encr_decr,
   input  logic [BLK_W-1:0]       core_data_out,
   input  logic                   core_done,
   output logic                   busy
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_e           state_q;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  rr_ptr_d;
   logic [WD_W-1:0]  wdog_q;
   logic             done_q;
   logic             rsp_valid_q;
   logic [BLK_W-1:0] rsp_data_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic             rsp_err_q;
   logic             core_start_q;
   logic [BLK_W-1:0] core_data_q;
   logic [KEY_W-1:0] core_key_q;
   logic             core_encr_q;

   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_any;
   logic             done_rise;
   logic             wd_exp;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (ID_W)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign rr_ptr_d  = ID_W'(wrap_inc(int'(gnt_idx), N_REQ));
   assign done_rise = core_done & ~done_q;
   assign wd_exp    = (wdog_q == WD_W'(TIMEOUT));

   // Accept is only offered while idle and out of reset.
   assign req_ready = (reset_ && state_q == IDLE) ? gnt : '0;
   assign busy      = (state_q != IDLE);

   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_id         = rsp_id_q;
   assign rsp_err        = rsp_err_q;
   assign core_start     = core_start_q;
   assign core_data_in   = core_data_q;
   assign core_key       = core_key_q;
   assign core_encr_decr = core_encr_q;

   // Delayed copy of core_done so only a fresh rising edge completes.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         done_q <= 1'b0;
      end else begin
         done_q <= core_done;
      end
   end

   // Job sequencer: grant, start pulse, wait/watchdog, response hold.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         wdog_q       <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= '0;
         rsp_err_q    <= 1'b0;
         core_start_q <= 1'b0;
         core_data_q  <= '0;
         core_key_q   <= '0;
         core_encr_q  <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt_any) begin
                  core_data_q  <= req_data[BLK_W*int'(gnt_idx) +: BLK_W];
                  core_key_q   <= req_key[KEY_W*int'(gnt_idx) +: KEY_W];
                  core_encr_q  <= req_encr[gnt_idx];
                  rsp_id_q     <= gnt_idx;
                  rr_ptr_q     <= rr_ptr_d;
                  core_start_q <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               core_start_q <= 1'b0;
               wdog_q       <= '0;
               state_q      <= WAIT;
            end
            WAIT: begin
               wdog_q <= wdog_q + WD_W'(1);
               if (done_rise) begin
                  rsp_data_q  <= core_data_out;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else if (wd_exp) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_magma_sched.sv
// Self-checking bench for magma_sched with a behavioural Magma core.
// Directed phases with randomized blocks/keys and a cipher reference model.
module tb_magma_sched;
   import magma_pkg::*;

   localparam int N   = 2;
   localparam int IDW = 1;
   localparam int TMO = 255;
   localparam int LAT = 130;

   localparam logic [63:0] PI [8] = '{
      64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F,
      64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
      64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0,
      64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
   };

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]     req_valid, req_ready, req_encr;
   logic [64*N-1:0]  req_data;
   logic [256*N-1:0] req_key;
   logic             rsp_valid, rsp_ready, rsp_err;
   logic [63:0]      rsp_data;
   logic [IDW-1:0]   rsp_id;
   logic             core_start, core_encr_decr, busy;
   logic [63:0]      core_data_in;
   logic [255:0]     core_key;
   logic [63:0]      core_data_out = '0;
   logic             core_done = 1'b0;

   int total = 0;
   int bad = 0;

   magma_sched #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_(reset_),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_key(req_key), .req_encr(req_encr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
      .core_start(core_start), .core_data_in(core_data_in),
      .core_key(core_key), .core_encr_decr(core_encr_decr),
      .core_data_out(core_data_out), .core_done(core_done),
      .busy(busy)
   );

   function automatic logic [31:0] gfun(input logic [31:0] a,
                                        input logic [31:0] k);
      logic [31:0] t, s;
      logic [63:0] row;
      int x;
      t = a + k;
      s = '0;
      for (int n = 0; n < 8; n++) begin
         row = PI[n];
         x = int'(t[4*n +: 4]);
         s[4*n +: 4] = row[60-4*x +: 4];
      end
      return {s[20:0], s[31:21]};
   endfunction

   function automatic logic [63:0] magma(input logic [63:0] blk,
                                         input logic [255:0] key,
                                         input logic enc);
      logic [31:0] a1, a0, t, kk;
      logic [63:0] res;
      int ki;
      res = '0;
      a1 = blk[63:32];
      a0 = blk[31:0];
      for (int r = 0; r < 32; r++) begin
         if (enc) ki = (r < 24) ? r % 8 : 7 - r % 8;
         else     ki = (r < 8)  ? r % 8 : 7 - r % 8;
         kk = key[255-32*ki -: 32];
         t = gfun(a0, kk) ^ a1;
         if (r < 31) begin
            a1 = a0;
            a0 = t;
         end else begin
            res = {t, a0};
         end
      end
      return res;
   endfunction

   // Behavioural core: result LAT cycles after start, level done.
   int   cm_cnt = 0;
   int   stale_cnt = 0;
   int   starts = 0;
   bit   hang = 0;
   bit   stale = 0;
   logic [63:0] cm_res = '0;

   always @(posedge clk) begin
      if (core_start) begin
         starts <= starts + 1;
         cm_cnt <= LAT;
         cm_res <= magma(core_data_in, core_key, core_encr_decr);
         if (stale) stale_cnt <= 3;
         else core_done <= 1'b0;
      end else begin
         if (stale_cnt > 0) begin
            stale_cnt <= stale_cnt - 1;
            if (stale_cnt == 1) core_done <= 1'b0;
         end
         if (cm_cnt > 1) begin
            cm_cnt <= cm_cnt - 1;
         end else if (cm_cnt == 1) begin
            cm_cnt <= 0;
            if (!hang) begin
               core_done     <= 1'b1;
               core_data_out <= cm_res;
            end
         end
      end
   end

   // Core inputs must not move while a job is in flight.
   logic [63:0]  cap_d = '0;
   logic [255:0] cap_k = '0;
   logic         cap_e = 1'b0;
   bit           cap_ok = 0;
   int           stab_bad = 0;

   always @(posedge clk) begin
      if (!reset_) begin
         cap_ok <= 0;
      end else if (core_start) begin
         cap_d  <= core_data_in;
         cap_k  <= core_key;
         cap_e  <= core_encr_decr;
         cap_ok <= 1;
      end else if (cap_ok && busy) begin
         if (core_data_in !== cap_d || core_key !== cap_k ||
             core_encr_decr !== cap_e)
            stab_bad <= stab_bad + 1;
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string p);
      chk({p, "_req_ready"}, 256'(req_ready), 256'(0));
      chk({p, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
      chk({p, "_rsp_data"}, 256'(rsp_data), 256'(0));
      chk({p, "_rsp_id"}, 256'(rsp_id), 256'(0));
      chk({p, "_rsp_err"}, 256'(rsp_err), 256'(0));
      chk({p, "_core_start"}, 256'(core_start), 256'(0));
      chk({p, "_core_data"}, 256'(core_data_in), 256'(0));
      chk({p, "_core_key"}, core_key, 256'(0));
      chk({p, "_core_mode"}, 256'(core_encr_decr), 256'(1));
      chk({p, "_busy"}, 256'(busy), 256'(0));
   endtask

   task automatic set_req(input int r, input logic [63:0] d,
                          input logic [255:0] k, input logic e);
      req_data[64*r +: 64]  = d;
      req_key[256*r +: 256] = k;
      req_encr[r]           = e;
      req_valid[r]          = 1'b1;
   endtask

   function automatic logic [255:0] rnd_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      return k;
   endfunction

   // Returns at the negedge after the grant edge; g = -1 on timeout.
   task automatic wait_grant(output int g);
      g = -1;
      for (int c = 0; c < 40; c++) begin
         #1;
         for (int i = 0; i < N; i++)
            if (g < 0 && req_ready[i]) g = i;
         if (g >= 0) break;
         @(negedge clk);
      end
      chk("grant_seen", 256'(g >= 0), 256'(1));
      if (g >= 0) @(negedge clk);
   endtask

   task automatic wait_rsp(input int bound, output int cyc);
      cyc = 0;
      while (!rsp_valid && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      chk("rsp_seen", 256'(rsp_valid), 256'(1));
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int g, cyc, s0, r, o, exp_ptr, exp_g;
      logic [63:0]  d, exp_d, hd;
      logic [255:0] k;
      logic [N-1:0] oh;
      logic [IDW-1:0] hid;
      bit stable;
      logic [63:0]  cd [N];
      logic [255:0] ck [N];
      logic         ce [N];

      req_valid = '0;
      req_encr  = '0;
      req_data  = '0;
      req_key   = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      req_valid = '1;
      #1 check_reset_vals("rst");
      req_valid = '0;
      @(negedge clk);
      reset_ = 1'b1;
      @(negedge clk);

      // Known-answer encrypt on requester 0.
      s0 = starts;
      set_req(0, TV_PT, TV_KEY, 1'b1);
      wait_grant(g);
      chk("enc_grant", 256'(g), 256'(0));
      chk("enc_busy", 256'(busy), 256'(1));
      req_valid[0] = 1'b0;
      wait_rsp(LAT + 50, cyc);
      chk("enc_data", 256'(rsp_data), 256'(TV_CT));
      chk("enc_id", 256'(rsp_id), 256'(0));
      chk("enc_err", 256'(rsp_err), 256'(0));
      chk("enc_starts", 256'(starts - s0), 256'(1));
      ack();

      // Known-answer decrypt on requester 1.
      set_req(1, TV_CT, TV_KEY, 1'b0);
      wait_grant(g);
      chk("dec_grant", 256'(g), 256'(1));
      req_valid[1] = 1'b0;
      wait_rsp(LAT + 50, cyc);
      chk("dec_data", 256'(rsp_data), 256'(TV_PT));
      chk("dec_id", 256'(rsp_id), 256'(1));
      ack();

      // Contention: all requesters stay valid, grants must rotate.
      exp_ptr = 0;
      for (int i = 0; i < N; i++) begin
         cd[i] = {$urandom, $urandom};
         ck[i] = rnd_key();
         ce[i] = 1'($urandom_range(0, 1));
         set_req(i, cd[i], ck[i], ce[i]);
      end
      for (int j = 0; j < 4; j++) begin
         exp_g = exp_ptr;
         exp_d = magma(cd[exp_g], ck[exp_g], ce[exp_g]);
         wait_grant(g);
         chk("rr_order", 256'(g), 256'(exp_g));
         cd[exp_g] = {$urandom, $urandom};
         ck[exp_g] = rnd_key();
         ce[exp_g] = 1'($urandom_range(0, 1));
         set_req(exp_g, cd[exp_g], ck[exp_g], ce[exp_g]);
         exp_ptr = (exp_g + 1) % N;
         wait_rsp(LAT + 50, cyc);
         chk("rr_id", 256'(rsp_id), 256'(exp_g));
         chk("rr_data", 256'(rsp_data), 256'(exp_d));
         chk("rr_err", 256'(rsp_err), 256'(0));
         ack();
      end
      req_valid = '0;
      @(negedge clk);

      // Backpressure: response held, other requester waits.
      r = $urandom_range(0, N - 1);
      o = (r + 1) % N;
      d = {$urandom, $urandom};
      k = rnd_key();
      set_req(r, d, k, 1'b1);
      wait_grant(g);
      chk("bp_grant", 256'(g), 256'(r));
      req_valid[r] = 1'b0;
      wait_rsp(LAT + 50, cyc);
      chk("bp_data", 256'(rsp_data), 256'(magma(d, k, 1'b1)));
      hd  = rsp_data;
      hid = rsp_id;
      cd[o] = {$urandom, $urandom};
      ck[o] = rnd_key();
      set_req(o, cd[o], ck[o], 1'b0);
      stable = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_id !== hid ||
             rsp_err !== 1'b0 || req_ready !== '0)
            stable = 0;
      end
      chk("bp_stable", 256'(stable), 256'(1));
      rsp_ready = 1'b1;
      #1 chk("bp_ready_held", 256'(req_ready), 256'(0));
      @(negedge clk);
      rsp_ready = 1'b0;
      oh = '0;
      oh[o] = 1'b1;
      #1 chk("bp_next_grant", 256'(req_ready), 256'(oh));
      chk("bp_rsp_clear", 256'(rsp_valid), 256'(0));
      wait_grant(g);
      chk("bp_grant2", 256'(g), 256'(o));
      req_valid[o] = 1'b0;
      wait_rsp(LAT + 50, cyc);
      chk("bp_data2", 256'(rsp_data), 256'(magma(cd[o], ck[o], 1'b0)));
      chk("bp_id2", 256'(rsp_id), 256'(o));
      ack();

      // Watchdog: core never completes.
      hang = 1;
      r = $urandom_range(0, N - 1);
      set_req(r, {$urandom, $urandom}, rnd_key(), 1'b1);
      wait_grant(g);
      req_valid[r] = 1'b0;
      wait_rsp(TMO + 50, cyc);
      chk("wd_err", 256'(rsp_err), 256'(1));
      chk("wd_data", 256'(rsp_data), 256'(0));
      chk("wd_id", 256'(rsp_id), 256'(r));
      chk("wd_window", 256'(cyc >= TMO && cyc <= TMO + 3), 256'(1));
      ack();
      chk("wd_idle", 256'(busy), 256'(0));
      hang = 0;

      // Reset in the middle of WAIT.
      r = $urandom_range(0, N - 1);
      set_req(r, {$urandom, $urandom}, rnd_key(), 1'b1);
      wait_grant(g);
      req_valid[r] = 1'b0;
      repeat (40) @(negedge clk);
      chk("mr_busy", 256'(busy), 256'(1));
      s0 = starts;
      reset_ = 1'b0;
      req_valid = '1;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      req_valid = '0;
      reset_ = 1'b1;
      repeat (LAT + 20) @(negedge clk);
      chk("mr_no_start", 256'(starts - s0), 256'(0));
      chk("mr_no_rsp", 256'(rsp_valid), 256'(0));
      chk("mr_idle", 256'(busy), 256'(0));

      // Stale done level on WAIT entry must not complete the job.
      stale = 1;
      r = $urandom_range(0, N - 1);
      d = {$urandom, $urandom};
      k = rnd_key();
      set_req(r, d, k, 1'b0);
      wait_grant(g);
      req_valid[r] = 1'b0;
      wait_rsp(LAT + 50, cyc);
      chk("st_late", 256'(cyc > LAT / 2), 256'(1));
      chk("st_data", 256'(rsp_data), 256'(magma(d, k, 1'b0)));
      chk("st_id", 256'(rsp_id), 256'(r));
      chk("st_err", 256'(rsp_err), 256'(0));
      ack();
      stale = 0;

      chk("core_in_stable", 256'(stab_bad), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
